light_seq_monitor: RTL and testbench

- Receive-side checker for the traffic-light controller's output bus.
- Samples the one-hot `light` code, plus the optional 2-bit `state` code, every clock.
- Decodes the current phase, tracks the expected red->yellow->green->red order, measures dwell per phase, counts completed cycles, and flags illegal codes, order violations and stuck phases.
- Sits beside the controller in the top level, or in the bench as a synthesizable protocol checker.

---
 rtl/light_seq_monitor.sv | 163 ++++++++++++++++
 tb/tb_light_seq_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/light_seq_monitor.sv
// light_seq_monitor: receive-side checker for the traffic-light controller bus.
// Decodes the one-hot light code, tracks the red->yellow->green->red order,
// measures per-phase dwell, counts completed cycles and flags illegal codes,
// order violations and stuck phases. All outputs are registered (one-cycle latency).
// Optional feature: define STATE_CHECK_EN to cross-check state_in against light_in;
// without it state_in is ignored and state_mismatch is tied to 0.
`timescale 1ns/1ps
module light_seq_monitor #(
    parameter int CNT_W     = 8,
    parameter int DWELL_W   = 4,
    parameter int MAX_DWELL = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         light_in,
    input  logic [1:0]         state_in,
    input  logic               err_clr,
    output logic               synced,
    output logic [1:0]         phase,
    output logic [DWELL_W-1:0] dwell,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               onehot_err,
    output logic               seq_err,
    output logic               timeout_err,
    output logic               state_mismatch,
    output logic               err_sticky
);

    // Encoding chosen so the phase output is the state code itself.
    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_YEL    = 2'd1,
        S_GRN    = 2'd2,
        S_UNSYNC = 2'd3
    } state_t;

    // Dwell value at which the phase has been held MAX_DWELL cycles.
    localparam logic [DWELL_W-1:0] TMO_DWELL = DWELL_W'(MAX_DWELL - 1);

    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d, dwell_sat;
    logic [CNT_W-1:0]     cnt_q;
    logic                 cnt_inc;
    logic                 legal;
    logic [1:0]           obs_code;
    logic                 oh_d, seq_d, tmo_d, mis_d, any_err_d;
    logic                 oh_q, seq_q, tmo_q, mis_q, sticky_q;

    // Expected successor in the red->yellow->green->red order.
    function automatic logic [1:0] succ(input logic [1:0] c);
        case (c)
            2'd0:    succ = 2'd1;
            2'd1:    succ = 2'd2;
            default: succ = 2'd0;
        endcase
    endfunction

    // Decode the sampled light code into legality and phase code.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        legal    = 1'b0;
        obs_code = 2'd3;
        case (light_in)
            3'b100: begin legal = 1'b1; obs_code = 2'd0; end
            3'b010: begin legal = 1'b1; obs_code = 2'd1; end
            3'b001: begin legal = 1'b1; obs_code = 2'd2; end
            default: ;
        endcase
    end

    // Saturating dwell increment.
    assign dwell_sat = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state_q <= S_UNSYNC;
        else     state_q <= state_d;
    end

    // FSM next-state logic plus the per-cycle event decisions.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        cnt_inc = 1'b0;
        oh_d    = 1'b0;
        seq_d   = 1'b0;
        tmo_d   = 1'b0;
        if (!legal) begin
            oh_d    = 1'b1;
            state_d = S_UNSYNC;
            dwell_d = '0;
        end else if (state_q == S_UNSYNC) begin
            state_d = state_t'(obs_code);
            dwell_d = '0;
        end else if (obs_code == 2'(state_q)) begin
            // Equality only occurs on the increment into TMO_DWELL, so the
            // pulse fires once even if the phase is held longer.
            dwell_d = dwell_sat;
            tmo_d   = (dwell_sat == TMO_DWELL);
        end else if (obs_code == succ(2'(state_q))) begin
            state_d = state_t'(obs_code);
            dwell_d = '0;
            cnt_inc = (state_q == S_GRN);
        end else begin
            seq_d   = 1'b1;
            state_d = state_t'(obs_code);
            dwell_d = '0;
        end
    end

`ifdef STATE_CHECK_EN
    // Cross-check the controller state code whenever the light code is legal.
    always_comb begin
        mis_d = legal && (state_in != obs_code);
    end
`else
    // state_in is deliberately unused in this build.
    logic unused_state_in;
    assign unused_state_in = ^state_in;
    assign mis_d = 1'b0;
`endif

    assign any_err_d = oh_d | seq_d | tmo_d | mis_d;

    // Datapath registers: dwell, cycle counter, error pulses and sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q  <= '0;
            cnt_q    <= '0;
            oh_q     <= 1'b0;
            seq_q    <= 1'b0;
            tmo_q    <= 1'b0;
            mis_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            oh_q    <= oh_d;
            seq_q   <= seq_d;
            tmo_q   <= tmo_d;
            mis_q   <= mis_d;
            // A new error in the same cycle wins over err_clr.
            if (any_err_d)    sticky_q <= 1'b1;
            else if (err_clr) sticky_q <= 1'b0;
        end
    end

    // FSM output decode from the registered state.
    always_comb begin
        synced = (state_q != S_UNSYNC);
        phase  = 2'(state_q);
    end

    assign dwell          = dwell_q;
    assign cycle_count    = cnt_q;
    assign onehot_err     = oh_q;
    assign seq_err        = seq_q;
    assign timeout_err    = tmo_q;
    assign state_mismatch = mis_q;
    assign err_sticky     = sticky_q;

endmodule

// File: tb/tb_light_seq_monitor.sv
// tb_light_seq_monitor: directed and randomized checks of light_seq_monitor
// against a phase-level reference model kept in the bench.
`timescale 1ns/1ps
module tb_light_seq_monitor;

    localparam int CNT_W     = 8;
    localparam int DWELL_W   = 4;
    localparam int MAX_DWELL = 8;
    localparam int DWELL_TOP = (1 << DWELL_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [2:0]         light_in = 3'b000;
    logic [1:0]         state_in = 2'd0;
    logic               err_clr = 1'b0;
    logic               synced;
    logic [1:0]         phase;
    logic [DWELL_W-1:0] dwell;
    logic [CNT_W-1:0]   cycle_count;
    logic               onehot_err, seq_err, timeout_err, state_mismatch, err_sticky;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    light_seq_monitor #(.CNT_W(CNT_W), .DWELL_W(DWELL_W), .MAX_DWELL(MAX_DWELL)) dut (
        .clk(clk), .rst(rst), .light_in(light_in), .state_in(state_in), .err_clr(err_clr),
        .synced(synced), .phase(phase), .dwell(dwell), .cycle_count(cycle_count),
        .onehot_err(onehot_err), .seq_err(seq_err), .timeout_err(timeout_err),
        .state_mismatch(state_mismatch), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase as 0/1/2, -1 when unsynced; held = cycles the phase has been seen.
    int m_ph = -1, m_held = 0, m_cnt = 0;
    bit m_oh, m_seq, m_tmo, m_mis, m_sticky;

    function automatic int code_of(input logic [2:0] l);
        if (l == 3'b100) return 0;
        if (l == 3'b010) return 1;
        if (l == 3'b001) return 2;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = -1; m_held = 0; m_cnt = 0;
            m_oh = 0; m_seq = 0; m_tmo = 0; m_mis = 0; m_sticky = 0;
        end else begin
            int c;
            c = code_of(light_in);
            m_oh = 0; m_seq = 0; m_tmo = 0; m_mis = 0;
            if (c < 0) begin
                m_oh = 1; m_ph = -1; m_held = 0;
            end else begin
`ifdef STATE_CHECK_EN
                m_mis = (int'(state_in) != c);
`endif
                if (m_ph < 0) begin
                    m_ph = c; m_held = 1;
                end else if (c == m_ph) begin
                    m_held++;
                    m_tmo = (m_held == MAX_DWELL);
                end else if (c == (m_ph + 1) % 3) begin
                    if (m_ph == 2) m_cnt++;
                    m_ph = c; m_held = 1;
                end else begin
                    m_seq = 1; m_ph = c; m_held = 1;
                end
            end
            if (m_oh || m_seq || m_tmo || m_mis) m_sticky = 1;
            else if (err_clr)                    m_sticky = 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            int exp_dwell;
            exp_dwell = (m_held == 0) ? 0 : ((m_held - 1 > DWELL_TOP) ? DWELL_TOP : m_held - 1);
            check("synced",         int'(synced),         int'(m_ph >= 0));
            check("phase",          int'(phase),          (m_ph < 0) ? 3 : m_ph);
            check("dwell",          int'(dwell),          exp_dwell);
            check("cycle_count",    int'(cycle_count),    m_cnt % (1 << CNT_W));
            check("onehot_err",     int'(onehot_err),     int'(m_oh));
            check("seq_err",        int'(seq_err),        int'(m_seq));
            check("timeout_err",    int'(timeout_err),    int'(m_tmo));
            check("state_mismatch", int'(state_mismatch), int'(m_mis));
            check("err_sticky",     int'(err_sticky),     int'(m_sticky));
        end
    end

    // Drive one sample, then wait until just after the edge that takes it.
    task automatic step(input logic [2:0] l, input logic [1:0] s, input logic c);
        light_in = l; state_in = s; err_clr = c;
        @(posedge clk); #1;
    endtask

    logic [2:0] bad_codes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        int tcount, tat, cur, r;
        logic [2:0] l;
        logic [1:0] s;

        // Reset values
        #12;
        check("rst_synced", int'(synced), 0);
        check("rst_phase",  int'(phase), 3);
        check("rst_count",  int'(cycle_count), 0);
        check("rst_sticky", int'(err_sticky), 0);
        @(posedge clk); #3 rst = 1'b0;
        run_cmp = 1'b1;

        // Four clean cycles
        for (int rep = 0; rep < 4; rep++) begin
            step(3'b100, 2'd0, 1'b0);
            check("t1_synced", int'(synced), 1);
            check("t1_dwell", int'(dwell), 0);
            step(3'b010, 2'd1, 1'b0);
            check("t1_dwell", int'(dwell), 0);
            step(3'b001, 2'd2, 1'b0);
            check("t1_dwell", int'(dwell), 0);
        end
        check("t1_count", int'(cycle_count), 3);
        check("t1_sticky", int'(err_sticky), 0);

        // Hold red for 10 cycles: timeout exactly once, on the 8th
        tcount = 0; tat = 0;
        for (int i = 1; i <= 10; i++) begin
            step(3'b100, 2'd0, 1'b0);
            if (timeout_err) begin tcount++; tat = i; end
        end
        check("t2_tmo_count", tcount, 1);
        check("t2_tmo_cycle", tat, 8);
        check("t2_dwell", int'(dwell), 9);
        check("t2_sticky", int'(err_sticky), 1);
        check("t2_count", int'(cycle_count), 4);

        // Clear, then skip yellow
        step(3'b100, 2'd0, 1'b1);
        check("t3_clr", int'(err_sticky), 0);
        step(3'b001, 2'd2, 1'b0);
        check("t3_seq", int'(seq_err), 1);
        check("t3_phase", int'(phase), 2);
        check("t3_count", int'(cycle_count), 4);
        step(3'b100, 2'd0, 1'b0);
        check("t3_count_inc", int'(cycle_count), 5);

        // Illegal code while in yellow, then resync
        step(3'b010, 2'd1, 1'b0);
        step(3'b110, 2'd1, 1'b0);
        check("t4_onehot", int'(onehot_err), 1);
        check("t4_synced", int'(synced), 0);
        check("t4_phase", int'(phase), 3);
        step(3'b010, 2'd1, 1'b0);
        check("t4_resync", int'(synced), 1);
        check("t4_noseq", int'(seq_err), 0);

        // err_clr against a new error, then alone
        step(3'b100, 2'd0, 1'b1);
        check("t5_seq", int'(seq_err), 1);
        check("t5_sticky_kept", int'(err_sticky), 1);
        step(3'b100, 2'd0, 1'b1);
        check("t5_sticky_clr", int'(err_sticky), 0);

        // State cross-check: yellow light reported as green
        step(3'b010, 2'd2, 1'b0);
`ifdef STATE_CHECK_EN
        check("t6_mismatch", int'(state_mismatch), 1);
`else
        check("t6_mismatch", int'(state_mismatch), 0);
`endif
        check("t6_noseq", int'(seq_err), 0);

        // Randomized traffic
        cur = 1;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                l = 3'b100 >> cur;
            end else if (r < 85) begin
                cur = (cur + 1) % 3;
                l = 3'b100 >> cur;
            end else if (r < 93) begin
                cur = $urandom_range(0, 2);
                l = 3'b100 >> cur;
            end else begin
                l = bad_codes[$urandom_range(0, 4)];
            end
            s = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'(cur);
            step(l, s, ($urandom_range(0, 9) == 0));

            // Asynchronous reset in the middle of the run
            if (i == 1500) begin
                #2 rst = 1'b1;
                #1;
                check("mid_rst_synced", int'(synced), 0);
                check("mid_rst_phase",  int'(phase), 3);
                check("mid_rst_count",  int'(cycle_count), 0);
                check("mid_rst_sticky", int'(err_sticky), 0);
                @(posedge clk); #3 rst = 1'b0;
            end
        end

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
